dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single data-memory port of the pipelined CPU. It shares the memory between the MEM-stage load/store path and a debug port used by the bench/monitor. It returns read data, and it raises a stall to the pipeline while a CPU access is pending. It sits between `U_SCPU` and `U_DM` inside `sccomp`.

---
 rtl/dmem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the CPU MEM-stage path and a
//   debug port. Writes complete in the grant cycle. Reads hold the port for
//   RD_LAT cycles after issue and then return dm_rdata to the owner.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   -> on conflict, round-robin between CPU and debug (last_gnt)
//   undefined -> fixed CPU priority; debug forced through after STARVE losses
//
// Parameters
//   DM_AW  : word-address width of the data memory
//   RD_LAT : cycles from read issue to valid dm_rdata (1..3)
//   STARVE : contended IDLE cycles a pending debug request may lose
//
// Ports
//   clk, rst                       : clock (rising), async active-high reset
//   cpu_req/we/addr/wdata          : CPU request, held until cpu_done
//   cpu_done, cpu_rdata, cpu_stall : CPU completion, load data, stall
//   dbg_req/we/addr/wdata          : debug request, held until dbg_done
//   dbg_done, dbg_rdata            : debug completion and load data
//   dm_we, dm_addr, dm_wdata       : memory write enable, word address, data
//   dm_rdata                       : memory read data
module dmem_arbiter #(
  parameter int DM_AW  = 7,
  parameter int RD_LAT = 1,
  parameter int STARVE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_done,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_done,
  output logic [31:0]      dbg_rdata,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;

  state_t           state_r, state_nxt_s;
  logic [1:0]       lat_cnt_r, lat_cnt_nxt_s;
  logic             owner_r, owner_nxt_s;
  logic [DM_AW-1:0] addr_r, addr_nxt_s;

  logic             gnt_dbg_s;
  logic             gnt_any_s;
  logic             sel_we_s;
  logic [31:0]      sel_addr_s;
  logic [31:0]      sel_wdata_s;

  logic             cpu_done_s, dbg_done_s, dm_we_s;
  logic [31:0]      cpu_rdata_s, dbg_rdata_s, dm_wdata_s;
  logic [DM_AW-1:0] dm_addr_s;

  // Byte-offset and above-window address bits are intentionally dropped.
  logic             unused_s;
  assign unused_s = ^{sel_addr_s[31:DM_AW+2], sel_addr_s[1:0]};

  assign gnt_any_s = cpu_req | dbg_req;

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_r;

  // Conflict resolution: grant whoever was not granted last.
  always_comb begin
    if (cpu_req && dbg_req) begin
      gnt_dbg_s = (last_gnt_r == OWN_CPU);
    end else begin
      gnt_dbg_s = dbg_req;
    end
  end

  // Remember the last grant; reset to debug so the CPU wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_r <= OWN_DBG;
    end else if ((state_r == IDLE) && gnt_any_s) begin
      last_gnt_r <= gnt_dbg_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end
`else
  localparam int             SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE);

  logic [SW-1:0] starve_cnt_r;
  logic          starved_s;

  assign starved_s = (starve_cnt_r == STARVE_MAX);

  // Fixed CPU priority unless debug has been passed over STARVE times.
  always_comb begin
    if (cpu_req && !starved_s) begin
      gnt_dbg_s = 1'b0;
    end else begin
      gnt_dbg_s = dbg_req;
    end
  end

  // Count IDLE cycles debug loses to the CPU; saturate, clear on debug grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if ((state_r == IDLE) && dbg_req) begin
      if (gnt_dbg_s) begin
        starve_cnt_r <= '0;
      end else if (!starved_s) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Steer the winning requester's attributes toward the memory port.
  always_comb begin
    if (gnt_dbg_s) begin
      sel_we_s    = dbg_we;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // Next-state and output decode; everything is forced to 0 while in reset.
  always_comb begin
    state_nxt_s   = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    owner_nxt_s   = owner_r;
    addr_nxt_s    = addr_r;
    cpu_done_s    = 1'b0;
    dbg_done_s    = 1'b0;
    cpu_rdata_s   = 32'h0000_0000;
    dbg_rdata_s   = 32'h0000_0000;
    dm_we_s       = 1'b0;
    dm_addr_s     = '0;
    dm_wdata_s    = 32'h0000_0000;
    if (!rst) begin
      case (state_r)
        IDLE: begin
          if (gnt_any_s) begin
            dm_addr_s  = sel_addr_s[DM_AW+1:2];
            dm_wdata_s = sel_wdata_s;
            if (sel_we_s) begin
              dm_we_s    = 1'b1;
              cpu_done_s = ~gnt_dbg_s;
              dbg_done_s = gnt_dbg_s;
            end else begin
              state_nxt_s   = RD_WAIT;
              lat_cnt_nxt_s = LAT_INIT;
              owner_nxt_s   = gnt_dbg_s;
              addr_nxt_s    = sel_addr_s[DM_AW+1:2];
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RD_WAIT: begin
          dm_addr_s = addr_r;
          if (lat_cnt_r == 2'd0) begin
            state_nxt_s = IDLE;
            if (owner_r == OWN_DBG) begin
              dbg_done_s  = 1'b1;
              dbg_rdata_s = dm_rdata;
            end else begin
              cpu_done_s  = 1'b1;
              cpu_rdata_s = dm_rdata;
            end
          end else begin
            lat_cnt_nxt_s = lat_cnt_r - 2'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // State, read latency counter, read owner and latched word address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      lat_cnt_r <= 2'd0;
      owner_r   <= OWN_CPU;
      addr_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      lat_cnt_r <= lat_cnt_nxt_s;
      owner_r   <= owner_nxt_s;
      addr_r    <= addr_nxt_s;
    end
  end

  assign cpu_done  = cpu_done_s;
  assign cpu_rdata = cpu_rdata_s;
  assign dbg_done  = dbg_done_s;
  assign dbg_rdata = dbg_rdata_s;
  assign dm_we     = dm_we_s;
  assign dm_addr   = dm_addr_s;
  assign dm_wdata  = dm_wdata_s;
  assign cpu_stall = cpu_req & ~cpu_done_s & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int RD_LAT = 2;
  localparam int DM_AW  = 7;

`ifdef DMEM_ARB_RR_EN
  localparam int          CONT_N   = 9;
  localparam logic [15:0] CPU_PATC = 16'h0111;
  localparam logic [15:0] DBG_PATC = 16'h0088;
`else
  localparam int          CONT_N   = 12;
  localparam logic [15:0] CPU_PATC = 16'h08FF;
  localparam logic [15:0] DBG_PATC = 16'h0400;
`endif

  logic             clk;
  logic             rst;
  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr, cpu_wdata;
  logic             cpu_done, cpu_stall;
  logic [31:0]      cpu_rdata;
  logic             dbg_req, dbg_we;
  logic [31:0]      dbg_addr, dbg_wdata;
  logic             dbg_done;
  logic [31:0]      dbg_rdata;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;

  logic [31:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  dmem_arbiter #(.DM_AW(DM_AW), .RD_LAT(RD_LAT), .STARVE(8)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on dm_we.
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    dm_rdata <= mem[dm_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: each done pops the expected read data (0 for writes).
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_done) begin
        if (cpu_q.size() == 0) check_val("cpu_extra_done", 32'(cpu_done), 32'd0);
        else check_val("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end else begin
        check_val("cpu_rdata_idle", cpu_rdata, 32'd0);
      end
      if (dbg_done) begin
        if (dbg_q.size() == 0) check_val("dbg_extra_done", 32'(dbg_done), 32'd0);
        else check_val("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end else begin
        check_val("dbg_rdata_idle", dbg_rdata, 32'd0);
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int  k;
    bit  got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cpu_q.push_back(we ? 32'd0 : exp_rdata);
    k = 0; got = 1'b0;
    while (!got && k <= 10) begin
      @(negedge clk);
      if (cpu_done) got = 1'b1;
      else begin
        check_val("cpu_stall_pending", 32'(cpu_stall), 32'd1);
        k++;
      end
    end
    check_val("cpu_latency", 32'(k), 32'(exp_lat));
    if (got) check_val("cpu_stall_done", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int  k;
    bit  got;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    dbg_q.push_back(we ? 32'd0 : exp_rdata);
    k = 0; got = 1'b0;
    while (!got && k <= 10) begin
      @(negedge clk);
      if (dbg_done) got = 1'b1;
      else k++;
    end
    check_val("dbg_latency", 32'(k), 32'(exp_lat));
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cpu_pat;
    logic [15:0] dbg_pat;
    int          k;
    bit          got;
    cpu_pat = CPU_PATC;
    dbg_pat = DBG_PATC;

    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
    #1 rst = 1'b1;
    // Requests present during reset must not leak to any output.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'hFFFF_FFFF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8;
    @(negedge clk);
    check_val("rst_dm_we", 32'(dm_we), 32'd0);
    check_val("rst_dm_addr", 32'(dm_addr), 32'd0);
    check_val("rst_cpu_done", 32'(cpu_done), 32'd0);
    check_val("rst_dbg_done", 32'(dbg_done), 32'd0);
    check_val("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // CPU write 0x8: same-cycle done, word address 2.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0008; cpu_wdata = 32'hDEAD_BEEF;
    cpu_q.push_back(32'd0);
    @(negedge clk);
    check_val("wr_dm_we", 32'(dm_we), 32'd1);
    check_val("wr_dm_addr", 32'(dm_addr), 32'd2);
    check_val("wr_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    check_val("wr_cpu_done", 32'(cpu_done), 32'd1);
    check_val("wr_cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // CPU read back: stall for RD_LAT cycles, then done.
    cpu_op(1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, RD_LAT);

    // Debug write; also makes debug the last grant before contention.
    dbg_op(1'b1, 32'h0000_0030, 32'h1234_5678, 32'd0, 0);

    // Contention: CPU write held, debug read held.
    for (int c = 0; c < CONT_N; c++) begin
      if (cpu_pat[c]) cpu_q.push_back(32'd0);
      if (dbg_pat[c]) dbg_q.push_back(32'h1234_5678);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE_0001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
    for (int c = 0; c < CONT_N; c++) begin
      @(negedge clk);
      check_val("cont_cpu_done", 32'(cpu_done), 32'(cpu_pat[c]));
      check_val("cont_dbg_done", 32'(dbg_done), 32'(dbg_pat[c]));
      @(posedge clk); #1;
      if (c == CONT_N - 2) dbg_req = 1'b0;
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;

    // Debug grant so the CPU wins the next conflict in either build.
    dbg_op(1'b1, 32'h0000_0030, 32'h1234_5678, 32'd0, 0);

    // CPU store and debug read to 0x10 together: store first, read sees it.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h0BAD_F00D;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    cpu_q.push_back(32'd0);
    dbg_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    check_val("t4_cpu_first", 32'(cpu_done), 32'd1);
    check_val("t4_dbg_wait", 32'(dbg_done), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k <= 10) begin
      @(negedge clk);
      if (dbg_done) got = 1'b1;
      else k++;
    end
    check_val("t4_dbg_latency", 32'(k), 32'(RD_LAT));
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(posedge clk); #1;

    // Reset one cycle into a CPU read: outputs drop at once, no done.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
    @(negedge clk);
    check_val("t5_stall_issue", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("t5_dm_we", 32'(dm_we), 32'd0);
    check_val("t5_dm_addr", 32'(dm_addr), 32'd0);
    check_val("t5_cpu_stall", 32'(cpu_stall), 32'd0);
    check_val("t5_cpu_done", 32'(cpu_done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("t5_no_done", 32'(cpu_done), 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    cpu_op(1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, RD_LAT);

    // Address wrap: 0x203 maps to word 0.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0203; cpu_wdata = 32'h5555_AAAA;
    cpu_q.push_back(32'd0);
    @(negedge clk);
    check_val("wrap_dm_addr", 32'(dm_addr), 32'd0);
    check_val("wrap_dm_we", 32'(dm_we), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dbg_op(1'b0, 32'h0000_0000, 32'd0, 32'h5555_AAAA, RD_LAT);
    cpu_op(1'b0, 32'hFFFF_FE00, 32'd0, 32'h5555_AAAA, RD_LAT);
    cpu_op(1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, RD_LAT);

    @(negedge clk);
    check_val("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    check_val("dbg_q_left", 32'(dbg_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
